mips_id_ex_control: RTL

Pipelined successor to the combinational main control decoder for the MIPS core. It decodes the ID-stage opcode into a control bundle and holds that bundle in the ID/EX pipeline register. It also owns load-use hazard detection: it stalls PC and IF/ID for a parametrised number of cycles and inserts bubbles, and it squashes the ID/EX bundle on a flush request. It sits between the IF/ID register and the EX stage.

---
 rtl/mips_id_ex_control_if.sv | 52 +++++
 rtl/mips_id_ex_control.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_id_ex_control_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_id_ex_control_if
// Description : Bundles the ID-stage inputs and the ID/EX control outputs of
//               mips_id_ex_control.
//               master : the pipeline side. It drives opcode/id_rs/id_rt/flush
//                        and consumes the stall enables and the EX bundle.
//               slave  : the control block.
// Ports       : opcode[5:0], id_rs[4:0], id_rt[4:0], flush        (to slave)
//               pc_write, ifid_write, ex_* control bits,
//               ex_alu_op[ALUOP_W-1:0], ex_rt[4:0]                (from slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_id_ex_control_if #(
  parameter int ALUOP_W = 3
);
  logic [5:0]         opcode;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               flush;
  logic               pc_write;
  logic               ifid_write;
  logic               ex_reg_dst;
  logic               ex_alu_src;
  logic               ex_mem_to_reg;
  logic               ex_reg_write;
  logic               ex_mem_read;
  logic               ex_mem_write;
  logic               ex_branch;
  logic               ex_branch_ne;
  logic               ex_jump;
  logic               ex_sign_zero;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [4:0]         ex_rt;

  modport master (
    output opcode, id_rs, id_rt, flush,
    input  pc_write, ifid_write,
    input  ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
    input  ex_mem_write, ex_branch, ex_branch_ne, ex_jump, ex_sign_zero,
    input  ex_alu_op, ex_rt
  );

  modport slave (
    input  opcode, id_rs, id_rt, flush,
    output pc_write, ifid_write,
    output ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write, ex_mem_read,
    output ex_mem_write, ex_branch, ex_branch_ne, ex_jump, ex_sign_zero,
    output ex_alu_op, ex_rt
  );
endinterface
`default_nettype wire

// File: rtl/mips_id_ex_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_id_ex_control
// Description : MIPS main control decoder with ID/EX pipeline register and
//               load-use hazard detection. Decodes the ID opcode, registers
//               the control bundle into EX, stalls PC and IF/ID for
//               LOAD_STALL cycles on a load-use hazard (inserting bubbles),
//               and squashes the ID/EX bundle on flush.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous, active-high
//               bus    - mips_id_ex_control_if.slave (ID inputs, stall
//                        enables, registered EX control bundle)
// Parameters  : ALUOP_W (>=3), EXT_OPS (0/1), LOAD_STALL (1..7)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_id_ex_control #(
  parameter int ALUOP_W    = 3,
  parameter int EXT_OPS    = 1,
  parameter int LOAD_STALL = 1
) (
  input wire logic             clk,
  input wire logic             reset,
  mips_id_ex_control_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_SLTI  = 6'b001010;
  localparam logic [5:0] c_OP_J     = 6'b000010;

  // Counter value loaded when entering STALL: the first stall cycle is spent
  // in RUN, the remaining LOAD_STALL-1 in STALL.
  localparam logic [2:0] c_STALL_INIT = 3'(LOAD_STALL - 1);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic               w_reg_dst;
  logic               w_alu_src;
  logic               w_mem_to_reg;
  logic               w_reg_write;
  logic               w_mem_read;
  logic               w_mem_write;
  logic               w_branch;
  logic               w_branch_ne;
  logic               w_jump;
  logic               w_sign_zero;
  logic [2:0]         w_alu_op3;
  logic [ALUOP_W-1:0] w_alu_op;

  logic               w_hazard;
  logic               w_stall;
  logic               w_bubble;
  state_t             w_state_nxt;
  logic [2:0]         w_cnt_nxt;

  state_t             r_state;
  logic [2:0]         r_cnt;

  logic               r_reg_dst;
  logic               r_alu_src;
  logic               r_mem_to_reg;
  logic               r_reg_write;
  logic               r_mem_read;
  logic               r_mem_write;
  logic               r_branch;
  logic               r_branch_ne;
  logic               r_jump;
  logic               r_sign_zero;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [4:0]         r_rt;

  // --------------------------------------------------------------------------
  // Main decoder. Extended opcodes fall through to the all-zero bundle when
  // EXT_OPS is 0.
  // --------------------------------------------------------------------------
  always_comb begin
    w_reg_dst    = 1'b0;
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_branch_ne  = 1'b0;
    w_jump       = 1'b0;
    w_sign_zero  = 1'b0;
    w_alu_op3    = 3'b000;
    case (bus.opcode)
      c_OP_RTYPE: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_alu_op3   = 3'b010;
      end
      c_OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
      end
      c_OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_BEQ: begin
        w_branch  = 1'b1;
        w_alu_op3 = 3'b001;
      end
      c_OP_BNE: begin
        if (EXT_OPS != 0) begin
          w_branch_ne = 1'b1;
          w_alu_op3   = 3'b001;
        end
      end
      c_OP_ADDI: begin
        if (EXT_OPS != 0) begin
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
        end
      end
      c_OP_ANDI: begin
        if (EXT_OPS != 0) begin
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
          w_sign_zero = 1'b1;
          w_alu_op3   = 3'b011;
        end
      end
      c_OP_ORI: begin
        if (EXT_OPS != 0) begin
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
          w_sign_zero = 1'b1;
          w_alu_op3   = 3'b100;
        end
      end
      c_OP_SLTI: begin
        if (EXT_OPS != 0) begin
          w_alu_src   = 1'b1;
          w_reg_write = 1'b1;
          w_alu_op3   = 3'b101;
        end
      end
      c_OP_J: begin
        if (EXT_OPS != 0) begin
          w_jump = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // ALU op is zero-extended to the configured width.
  generate
    if (ALUOP_W > 3) begin : g_aluop_wide
      assign w_alu_op = {{(ALUOP_W-3){1'b0}}, w_alu_op3};
    end else begin : g_aluop_min
      assign w_alu_op = w_alu_op3;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Load-use hazard: the load now in EX writes a register the ID instruction
  // reads. Register 0 never creates a dependency.
  // --------------------------------------------------------------------------
  assign w_hazard = r_mem_read & (r_rt != 5'd0) &
                    ((r_rt == bus.id_rs) | (r_rt == bus.id_rt));

  // --------------------------------------------------------------------------
  // Stall FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Stall FSM: next state and stall request. Flush overrides everything and
  // aborts any stall in progress.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = 3'd0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hazard) begin
            w_stall = 1'b1;
            if (LOAD_STALL > 1) begin
              w_state_nxt = S_STALL;
              w_cnt_nxt   = c_STALL_INIT;
            end
          end
        end
        S_STALL: begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 3'd1;
          // cnt<=1 also catches a corrupted zero count, so STALL cannot hang.
          if (r_cnt <= 3'd1) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 3'd0;
        end
      endcase
    end
  end

  // Reset keeps the front end moving.
  assign bus.pc_write   = reset | ~w_stall;
  assign bus.ifid_write = reset | ~w_stall;

  // A bubble is loaded for both stalls and flushes.
  assign w_bubble = bus.flush | w_stall;

  // --------------------------------------------------------------------------
  // ID/EX pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_reg_dst    <= 1'b0;
      r_alu_src    <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_branch_ne  <= 1'b0;
      r_jump       <= 1'b0;
      r_sign_zero  <= 1'b0;
      r_alu_op     <= '0;
      r_rt         <= 5'd0;
    end else begin
      r_reg_dst    <= w_reg_dst;
      r_alu_src    <= w_alu_src;
      r_mem_to_reg <= w_mem_to_reg;
      r_reg_write  <= w_reg_write;
      r_mem_read   <= w_mem_read;
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_branch_ne  <= w_branch_ne;
      r_jump       <= w_jump;
      r_sign_zero  <= w_sign_zero;
      r_alu_op     <= w_alu_op;
      r_rt         <= bus.id_rt;
    end
  end

  assign bus.ex_reg_dst    = r_reg_dst;
  assign bus.ex_alu_src    = r_alu_src;
  assign bus.ex_mem_to_reg = r_mem_to_reg;
  assign bus.ex_reg_write  = r_reg_write;
  assign bus.ex_mem_read   = r_mem_read;
  assign bus.ex_mem_write  = r_mem_write;
  assign bus.ex_branch     = r_branch;
  assign bus.ex_branch_ne  = r_branch_ne;
  assign bus.ex_jump       = r_jump;
  assign bus.ex_sign_zero  = r_sign_zero;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_rt         = r_rt;

endmodule
`default_nettype wire
